ex_muldiv_sequencer: RTL

// - Iterative RV32M multiply/divide engine plus its control FSM, beside the execute stage ALU.
// - Accepts one M-extension op from execute, stalls the pipeline through the hazard unit while it

---
 rtl/ex_muldiv_sequencer_if.sv | 30 +++
 rtl/ex_muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_sequencer_if                                       |
// | Description : Execute-stage <-> M-extension sequencer handshake bundle.     |
// |               master = execute/hazard side, slave = the sequencer.         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface ex_muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            invalidate;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand_a, operand_b, invalidate,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, invalidate,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_sequencer                                          |
// | Description : Iterative RV32M multiply/divide engine with control FSM.     |
// |               Shift-add multiplier, restoring divider, sign fix-up, abort. |
// |               Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplies.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ex_muldiv_sequencer_if.slave  bus
);

    localparam int c_CW = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [2:0] c_F3_MUL    = 3'd0;
    localparam logic [2:0] c_F3_MULH   = 3'd1;
    localparam logic [2:0] c_F3_MULHSU = 3'd2;
    localparam logic [2:0] c_F3_MULHU  = 3'd3;
    localparam logic [2:0] c_F3_DIV    = 3'd4;
    localparam logic [2:0] c_F3_DIVU   = 3'd5;
    localparam logic [2:0] c_F3_REM    = 3'd6;
    localparam logic [2:0] c_F3_REMU   = 3'd7;

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // State and datapath registers. r_hi/r_lo hold the running product
    // (multiply) or remainder/quotient-in-progress (divide).
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    // Operand decode wires
    logic            w_is_div;
    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_div_ovf;

    // Iteration and fix-up wires
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;
    logic              w_busy;

    // Decode signedness, magnitudes and the two divide special cases from the incoming op
    always_comb begin
        w_is_div   = bus.funct3[2];
        // Divides: DIV/REM signed (funct3[0]==0). Multiplies: only MULHU leaves a unsigned.
        w_sign_a   = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        // Multiplies: only MUL/MULH treat b as signed.
        w_sign_b   = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
        w_neg_a    = w_sign_a & bus.operand_a[XLEN-1];
        w_neg_b    = w_sign_b & bus.operand_b[XLEN-1];
        w_mag_a    = w_neg_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
        w_mag_b    = w_neg_b ? (~bus.operand_b + 1'b1) : bus.operand_b;
        w_div_zero = w_is_div & (bus.operand_b == '0);
        w_div_ovf  = w_is_div & ~bus.funct3[0] & (bus.operand_a == c_INT_MIN)
                   & (bus.operand_b == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single signed product of sign/zero-extended operands; low 2*XLEN bits are exact.
    logic [2*XLEN-1:0] w_fast_a;
    logic [2*XLEN-1:0] w_fast_b;
    logic [2*XLEN-1:0] w_fast_prod;

    // Extend operands according to their signedness before the one-shot multiply
    always_comb begin
        w_fast_a    = {{XLEN{w_sign_a & bus.operand_a[XLEN-1]}}, bus.operand_a};
        w_fast_b    = {{XLEN{w_sign_b & bus.operand_b[XLEN-1]}}, bus.operand_b};
        w_fast_prod = w_fast_a * w_fast_b;
    end
`endif

    // One shift-add multiply step and one restoring divide step, computed every cycle
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : {(XLEN+1){1'b0}});
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_op};
        // Partial remainder is always below 2*divisor, so the borrow bit decides the quotient bit.
        w_div_ge    = ~w_div_diff[XLEN];
    end

    // Final sign fix-up and half/quotient/remainder selection
    always_comb begin
        w_prod       = {r_hi, r_lo};
        w_prod_fix   = r_neg_q ? (~w_prod + 1'b1) : w_prod;
        w_quo_fix    = r_neg_q ? (~r_lo + 1'b1) : r_lo;
        w_rem_fix    = r_neg_r ? (~r_hi + 1'b1) : r_hi;
        w_fix_result = '0;
        case (r_f3)
            c_F3_MUL:                          w_fix_result = w_prod_fix[XLEN-1:0];
            c_F3_MULH, c_F3_MULHSU, c_F3_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            c_F3_DIV, c_F3_DIVU:               w_fix_result = w_quo_fix;
            c_F3_REM, c_F3_REMU:               w_fix_result = w_rem_fix;
            default:                           w_fix_result = '0;
        endcase
    end

    // Stall request; dropped in the done cycle so execute advances as it captures result
    always_comb begin
        w_busy = ~r_done & (((r_state == c_IDLE) & bus.start & ~bus.invalidate)
                            | (r_state == c_ITER) | (r_state == c_FIX));
    end

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.invalidate) begin
                // Flush: abandon the op, result keeps its previous value.
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (bus.start) begin
                            r_f3    <= bus.funct3;
                            r_cnt   <= '0;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            if (w_div_zero) begin
                                // Quotient all ones, remainder = dividend, no sign fix-up.
                                r_hi    <= bus.operand_a;
                                r_lo    <= '1;
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= c_FIX;
                            end else if (w_div_ovf) begin
                                r_hi    <= '0;
                                r_lo    <= c_INT_MIN;
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= c_FIX;
`ifdef MULDIV_FAST_MUL_EN
                            end else if (!w_is_div) begin
                                // Product is already signed; skip the magnitude fix-up.
                                {r_hi, r_lo} <= w_fast_prod;
                                r_neg_q      <= 1'b0;
                                r_neg_r      <= 1'b0;
                                r_state      <= c_FIX;
`endif
                            end else if (w_is_div) begin
                                r_hi    <= '0;
                                r_lo    <= w_mag_a;
                                r_op    <= w_mag_b;
                                r_state <= c_ITER;
                            end else begin
                                // Multiplier sits in r_lo and shifts out as the product shifts in.
                                r_hi    <= '0;
                                r_lo    <= w_mag_b;
                                r_op    <= w_mag_a;
                                r_state <= c_ITER;
                            end
                        end
                    end
                    c_ITER: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_f3[2]) begin
                            r_hi <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                        end else begin
                            {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
                        end
                        if (r_cnt == c_LAST) begin
                            r_state <= c_FIX;
                        end
                    end
                    c_FIX: begin
                        r_result <= w_fix_result;
                        r_done   <= 1'b1;
                        r_state  <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
